// File: rtl/bram_playback_pkg.sv
// Shared FSM encoding and drain-length derivation for the BRAM playback reader.
// Pure constants and one helper function; no logic, no latency, no flow control.
package bram_playback_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Wide enough to count a drain of READ_LATENCY+1 cycles for latencies up to 7.
  localparam int DRAIN_CNT_W = 3;

  // The last read issued needs READ_LATENCY BRAM clocks plus the dout register.
  function automatic int drain_cycles(input int read_latency);
    return read_latency + 1;
  endfunction

endpackage

// File: rtl/bram_playback_reader_if.sv
// BRAM read port plus the registered sample stream of the playback reader.
// master = the reader (drives address/enable and the sample stream); slave = BRAM and sample consumer.
interface bram_playback_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           bram_addr;
  logic                  bram_en;
  logic [DATA_WIDTH-1:0] bram_rddata;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;

  modport master (
    output bram_addr,
    output bram_en,
    input  bram_rddata,
    output dout,
    output dout_valid
  );

  modport slave (
    input  bram_addr,
    input  bram_en,
    output bram_rddata,
    input  dout,
    input  dout_valid
  );
endinterface

// File: rtl/bram_playback_reader_valid_delay_line.sv
// Shift register tracking which cycles carry a live BRAM read; DEPTH clocks from vld_i to vld_o.
// capture_o fires one clock earlier so the data register loads on the edge vld_o rises. No backpressure.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  output logic capture_o,
  output logic vld_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], vld_i};
    end
  end

  assign capture_o = pipe_q[DEPTH-2];
  assign vld_o     = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_playback_reader.sv
// Streams a BRAM buffer out word by word on trig; dout_valid lags bram_en by READ_LATENCY+1 clocks.
// clken stalls address issue only; in-flight reads always complete, so stalls become valid gaps.
module bram_playback_reader
  import bram_playback_pkg::*;
#(
  parameter int COUNT_WIDTH  = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clken,
  input  logic                    trig,
  input  logic                    continuous,
  input  logic                    stop,
  bram_playback_reader_if.master  bus,
  output logic                    busy,
  output logic                    done
);

  localparam int                     DRAIN_LEN  = drain_cycles(READ_LATENCY);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [DRAIN_CNT_W-1:0]  drain_q, drain_d;
  logic                    trig_q;
  logic                    armed_q;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   dout_q;

  logic                    trig_rise;
  logic                    bram_en;
  logic                    capture;
  logic                    dout_vld;

  // armed_q blocks a trig that was already high when reset released.
  assign trig_rise = trig & ~trig_q & armed_q;
  assign bram_en   = (state_q == ST_RUN) & clken;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_rise && !done_q) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (clken) begin
          if (count_q == COUNT_MAX && !(continuous && !stop)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      drain_q <= '0;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drain_q <= drain_d;
      trig_q  <= trig;
      armed_q <= armed_q | ~trig;
      done_q  <= done_d;
      if (capture) begin
        dout_q <= bus.bram_rddata;
      end
    end
  end

  valid_delay_line #(
    .DEPTH (DRAIN_LEN)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .vld_i     (bram_en),
    .capture_o (capture),
    .vld_o     (dout_vld)
  );

  assign bus.bram_addr  = 32'(count_q) << 2;
  assign bus.bram_en    = bram_en;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_vld;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_bram_playback_reader.sv
// Three readers (READ_LATENCY 2, 1, 4; 8-word buffer) share one stimulus stream and are each
// compared every cycle against a queue-based model of the playback rules.
module tb_bram_playback_reader;

  localparam int CW = 3;
  localparam int NW = 1 << CW;
  localparam int DW = 32;

  typedef struct {
    int due;
    int word;
  } rd_t;

  typedef struct {
    bit          cont;
    int          ckmode;     // 0 always on, 1 toggling, 2 random
    int          stop_after;
    bit          extra_trig;
    int          rst_at;
    int          exp_valid;  // negative: not compared
    int          exp_done;
    logic [31:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clken = 1'b0;
  logic trig = 1'b0;
  logic continuous = 1'b0;
  logic stop = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tag(input int dut, input logic [31:0] addr);
    return {8'hA5, 8'(dut), addr[15:0]};
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      localparam int RL = (g == 0) ? 2 : (g == 1) ? 1 : 4;

      bram_playback_reader_if #(.DATA_WIDTH(DW)) bus ();
      logic busy;
      logic done;
      logic [31:0] ahist [5] = '{default: '0};

      bram_playback_reader #(
        .COUNT_WIDTH  (CW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .trig       (trig),
        .continuous (continuous),
        .stop       (stop),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
      );

      // BRAM: data for the address presented RL clocks earlier, tagged with its address.
      always @(posedge clk) begin
        ahist[0] <= bus.bram_addr;
        for (int i = 1; i < 5; i++) ahist[i] <= ahist[i-1];
      end
      assign bus.bram_rddata = tag(g, ahist[RL-1]);

      bit running = 1'b0;
      bit m_done = 1'b0;
      bit prev_trig = 1'b0;
      bit armed = 1'b0;
      int drain_left = 0;
      int word = 0;
      int cyc = 0;
      int issued = 0;
      int nvalid = 0;
      int ndone = 0;
      logic [DW-1:0] m_dout = '0;
      rd_t pend[$];

      initial forever begin
        bit rise, was_done, e_en, e_valid, e_busy;
        rd_t r;
        @(negedge clk);
        if (rst) begin
          running = 1'b0; m_done = 1'b0; prev_trig = 1'b0; armed = 1'b0;
          drain_left = 0; word = 0; m_dout = '0;
          pend.delete();
        end
        e_en    = running && clken && !rst;
        e_busy  = running || (drain_left > 0);
        e_valid = (pend.size() > 0) && (pend[0].due == cyc);
        if (e_valid) begin
          m_dout = tag(g, 32'(pend[0].word * 4));
          void'(pend.pop_front());
        end
        check($sformatf("dut%0d c%0d bram_en", g, cyc), bus.bram_en, e_en);
        check($sformatf("dut%0d c%0d bram_addr", g, cyc), bus.bram_addr, word * 4);
        check($sformatf("dut%0d c%0d dout_valid", g, cyc), bus.dout_valid, e_valid);
        check($sformatf("dut%0d c%0d dout", g, cyc), bus.dout, m_dout);
        check($sformatf("dut%0d c%0d busy", g, cyc), busy, e_busy);
        check($sformatf("dut%0d c%0d done", g, cyc), done, m_done);
        nvalid += int'(bus.dout_valid === 1'b1);
        ndone  += int'(done === 1'b1);
        if (!rst) begin
          rise     = trig && !prev_trig && armed;
          was_done = m_done;
          m_done   = 1'b0;
          if (running) begin
            if (clken) begin
              r.due  = cyc + RL + 1;
              r.word = word;
              pend.push_back(r);
              issued++;
              if (word == NW - 1 && !(continuous && !stop)) begin
                running    = 1'b0;
                drain_left = RL + 1;
              end else begin
                word = (word + 1) % NW;
              end
            end
          end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) m_done = 1'b1;
          end else if (rise && !was_done) begin
            running = 1'b1;
            word    = 0;
          end
          if (!trig) armed = 1'b1;
          prev_trig = trig;
        end
        cyc++;
      end
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_busy();
    return gd[0].running || gd[0].drain_left > 0 ||
           gd[1].running || gd[1].drain_left > 0 ||
           gd[2].running || gd[2].drain_left > 0;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (any_busy() && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, n);
    end
    repeat (3) step();
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    check({name, " bram_en"}, gd[0].bus.bram_en, 0);
    check({name, " bram_addr"}, gd[0].bus.bram_addr, 0);
    check({name, " dout_valid"}, gd[0].bus.dout_valid, 0);
    check({name, " dout"}, gd[0].bus.dout, 0);
    check({name, " busy"}, gd[0].busy, 0);
    check({name, " done"}, gd[0].done, 0);
  endtask

  task automatic run_scn(input int idx, input vec_t v);
    int b_iss, n;
    int v0 [3];
    int d0 [3];
    int dv [3];
    int dd [3];
    b_iss = gd[0].issued;
    v0[0] = gd[0].nvalid; v0[1] = gd[1].nvalid; v0[2] = gd[2].nvalid;
    d0[0] = gd[0].ndone;  d0[1] = gd[1].ndone;  d0[2] = gd[2].ndone;
    continuous = v.cont; stop = 1'b0; trig = 1'b0; clken = 1'b1;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while (any_busy() && n < 1000) begin
      clken = (v.ckmode == 0) ? 1'b1 : (v.ckmode == 1) ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (v.stop_after > 0 && gd[0].issued - b_iss >= v.stop_after) stop = 1'b1;
      if (v.extra_trig) trig = gd[0].running && (n % 3 == 1);
      if (v.rst_at > 0 && gd[0].issued - b_iss == v.rst_at) begin
        rst = 1'b1;
        check_quiet($sformatf("scn%0d rst_mid_run", idx));
        step();
        rst = 1'b0;
      end
      step();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL scn%0d timeout: busy after %0d cycles, required idle", idx, n);
    end
    trig = 1'b0;
    clken = 1'b1;
    repeat (3) step();
    dv[0] = gd[0].nvalid - v0[0]; dv[1] = gd[1].nvalid - v0[1]; dv[2] = gd[2].nvalid - v0[2];
    dd[0] = gd[0].ndone - d0[0];  dd[1] = gd[1].ndone - d0[1];  dd[2] = gd[2].ndone - d0[2];
    for (int k = 0; k < 3; k++) begin
      if (v.exp_valid >= 0) check($sformatf("scn%0d dut%0d valid_count", idx, k), dv[k], v.exp_valid);
      check($sformatf("scn%0d dut%0d done_count", idx, k), dd[k], v.exp_done);
    end
    check($sformatf("scn%0d final_addr", idx), gd[0].bus.bram_addr, v.exp_addr);
  endtask

  initial begin
    vec_t vt [7];
    int b_v, b_d, n;
    //         cont  ck  stop extra rst  valid done addr
    vt[0] = '{1'b0, 0, 0,  1'b0, 0, 8,  1, 32'd28};
    vt[1] = '{1'b0, 1, 0,  1'b0, 0, 8,  1, 32'd28};
    vt[2] = '{1'b0, 2, 0,  1'b0, 0, 8,  1, 32'd28};
    vt[3] = '{1'b1, 0, 20, 1'b0, 0, 24, 1, 32'd28};
    vt[4] = '{1'b1, 2, 20, 1'b0, 0, 24, 1, 32'd28};
    vt[5] = '{1'b0, 0, 0,  1'b1, 0, 8,  1, 32'd28};
    vt[6] = '{1'b0, 0, 0,  1'b0, 4, -1, 0, 32'd0};

    rst = 1'b1;
    step();
    step();
    check_quiet("reset");
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_scn(i, vt[i]);

    // trig held high across reset release must not start a pass
    trig = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    check("held_trig no_start busy", gd[0].busy, 0);
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("held_trig restart busy", gd[0].busy, 1);
    wait_idle("held_trig pass");

    // a rising edge landing on the done cycle is ignored
    b_v = gd[0].nvalid;
    b_d = gd[0].ndone;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while (!gd[0].m_done && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL done_edge timeout: no done after %0d cycles", n);
    end
    trig = 1'b1;
    step();
    check("done_edge ignored busy", gd[0].busy, 0);
    trig = 1'b0;
    wait_idle("done_edge settle");
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("done_edge restart busy", gd[0].busy, 1);
    wait_idle("done_edge second pass");
    check("done_edge valid_count", gd[0].nvalid - b_v, 16);
    check("done_edge done_count", gd[0].ndone - b_d, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
